bus_arb: RTL and testbench
==========================

# bus_arb

Single-port memory bus arbiter sitting directly downstream of the multicycle CPU core. It accepts instruction-fetch requests (ifu) and load/store requests (lsu), serialises them onto one word-wide memory port and returns responses. It also performs byte-lane alignment, so the core sees LSB-aligned load data and supplies unshifted store data and masks.

## Interface
- TIMEOUT_CYCLES, 255: watchdog limit in cycles; used only with BUS_ARB_TIMEOUT_EN.
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; all state cleared immediately.
- ifu_reqValid  in  1  fetch request.
- ifu_addr  in  32  fetch address; word-aligned.
- ifu_respValid  out  1  one-cycle pulse; ifu_rdata valid.
- ifu_rdata  out  32  fetched word.
- lsu_reqValid  in  1  load/store request.
- lsu_addr  in  32  byte address.
- lsu_size  in  2  0 byte, 1 half, 2 word; 3 reserved, treated as word.
- lsu_wen  in  1  1 store, 0 load.
- lsu_wdata  in  32  store data, LSB-aligned.
- lsu_wmask  in  4  byte mask, LSB-aligned (4'b0001 / 4'b0011 / 4'b1111).
- lsu_respValid  out  1  one-cycle pulse; load data or store ack.
- lsu_rdata  out  32  load data shifted right by addr[1:0], upper bytes as read; the core sign-extends.
- lsu_misalign  out  1  pulses with lsu_respValid on a rejected misaligned access.
- mem_req  out  1  memory request, held until mem_ready.
- mem_addr  out  32  {addr[31:2],2'b00}.
- mem_wen  out  1  write.
- mem_wdata  out  32  lsu_wdata << 8*addr[1:0].
- mem_wmask  out  4  lsu_wmask << addr[1:0]; 4'b0000 on reads.
- mem_ready  in  1  memory accepts request this cycle.
- mem_rvalid  in  1  read data / write ack; earliest the cycle after acceptance.
- mem_rdata  in  32  read word.
- bus_err  out  1  timeout pulse; tied 0 when feature is off.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE, lsu_reqValid=1:
  - Misaligned access (size=1 with addr[0]=1, or size=2 with addr[1:0]≠0) goes to RESP with no memory access, rdata 0, misalign set.
  - Otherwise latch the lsu request and go to REQ.
- IDLE, ifu_reqValid=1 and lsu_reqValid=0: latch the ifu request and go to REQ. With both valid, lsu wins; ifu stays pending while its reqValid stays high.
- REQ: mem_req=1 with registered addr/wen/wdata/wmask. On mem_ready go to WAIT.
- WAIT: on mem_rvalid register rdata (ifu raw; lsu shifted right by 8*addr[1:0]) and go to RESP.
- RESP: pulse the owner's respValid for one cycle, then go to IDLE.
- reqValid is ignored outside IDLE. The requester drops reqValid no later than the respValid cycle; reqValid high in the cycle after RESP is a new request.
- Request fields are captured in IDLE; later changes on the inputs are ignored.
- mem_rvalid outside WAIT is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, latched request cleared.
- Reset mid-transaction aborts it; no respValid is issued.
- Zero-wait memory: reqValid at cycle 0, mem_req at 1 (mem_ready at 1), mem_rvalid at 2, respValid at 3. Minimum latency is 3 cycles.
- Misaligned access: lsu_respValid and lsu_misalign at cycle 1.
- Each mem_ready stall cycle adds 1 cycle; each mem_rvalid wait cycle adds 1 cycle.
- Back-to-back requests: a new request is accepted at the earliest in the cycle after RESP (IDLE).

## Configuration
- BUS_ARB_TIMEOUT_EN defined: an 8+ bit counter clears on entering REQ and counts in REQ/WAIT.
  - When the count reaches TIMEOUT_CYCLES, go to RESP with rdata 32'hDEADBEEF and pulse bus_err alongside respValid.
  - mem_req drops at timeout.
- Undefined: no counter; bus_err constant 0; the FSM waits indefinitely.

## Structure
- Package bus_pkg: state enum (IDLE/REQ/WAIT/RESP), SIZE_BYTE/SIZE_HALF/SIZE_WORD constants, owner enum (OWN_IFU/OWN_LSU), DEADBEEF constant.
- Sub-module lane_align: combinational store shift (wdata, wmask) and load shift (rdata) by addr[1:0]; bus_arb instantiates one.

## Test plan
- ifu fetch at 0x8000_0000, mem_rdata 0x0010_0093, zero-wait -> mem_addr 0x8000_0000 at cycle 1; ifu_respValid with 0x0010_0093 at cycle 3.
- Byte load at 0x1000_0003, mem_rdata 0xAB11_2233 -> mem_wmask 0; lsu_rdata 0x0000_00AB.
- Half store 0xBEEF at 0x2000_0002, mask 4'b0011 -> mem_addr 0x2000_0000, mem_wdata 0xBEEF_0000, mem_wmask 4'b1100, mem_wen 1; ack -> lsu_respValid.
- Both reqValid high in IDLE -> lsu served first; ifu served after; each respValid pulses once.
- Word load at 0x0000_0006 -> no mem_req; lsu_respValid and lsu_misalign at cycle 1, rdata 0.
- mem_ready held low 5 cycles, then reset asserted mid-REQ -> outputs 0 immediately, no respValid; with BUS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, no mem_rvalid -> bus_err and rdata 0xDEADBEEF.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types, size encodings and misalignment check for the bus arbiter
package bus_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;
  typedef enum logic {OWN_IFU, OWN_LSU} owner_e;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;
  // reserved size 3 behaves like a word access
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == SIZE_HALF && off[0]) ||
           (size != SIZE_BYTE && size != SIZE_HALF && off != 2'd0);
  endfunction
endpackage

// File: rtl/bus_arb_if.sv
// bus_arb_if: core request/response and memory port signals of the bus arbiter
interface bus_arb_if;
  logic        ifu_reqValid;
  logic [31:0] ifu_addr;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;
  logic        lsu_reqValid;
  logic [31:0] lsu_addr;
  logic [1:0]  lsu_size;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;
  logic        lsu_misalign;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        bus_err;
  modport slave (
    input  ifu_reqValid, ifu_addr, lsu_reqValid, lsu_addr, lsu_size, lsu_wen,
           lsu_wdata, lsu_wmask, mem_ready, mem_rvalid, mem_rdata,
    output ifu_respValid, ifu_rdata, lsu_respValid, lsu_rdata, lsu_misalign,
           mem_req, mem_addr, mem_wen, mem_wdata, mem_wmask, bus_err
  );
  modport master (
    output ifu_reqValid, ifu_addr, lsu_reqValid, lsu_addr, lsu_size, lsu_wen,
           lsu_wdata, lsu_wmask, mem_ready, mem_rvalid, mem_rdata,
    input  ifu_respValid, ifu_rdata, lsu_respValid, lsu_rdata, lsu_misalign,
           mem_req, mem_addr, mem_wen, mem_wdata, mem_wmask, bus_err
  );
endinterface

// File: rtl/bus_arb_lane_align.sv
// lane_align: byte-lane shifts between LSB-aligned core data and word-wide memory lanes
module lane_align (
  input  logic [1:0]  st_off_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wmask_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wmask_o,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o
);
  assign wdata_o = wdata_i << {st_off_i, 3'b000};
  assign wmask_o = wmask_i << st_off_i;
  assign rdata_o = rdata_i >> {ld_off_i, 3'b000};
endmodule

// File: rtl/bus_arb.sv
// bus_arb: serialises ifu fetches and lsu loads/stores onto one memory port (lsu has priority).
// Optional watchdog enabled by BUS_ARB_TIMEOUT_EN.
module bus_arb
`ifdef BUS_ARB_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
  input logic      clock,
  input logic      reset,
  bus_arb_if.slave bus
);
  import bus_pkg::*;
  state_e      state_q;
  owner_e      owner_q;
  logic [1:0]  off_q;
  logic [31:0] ifu_rdata_q, lsu_rdata_q, mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_wmask_q;
  logic        mem_req_q, mem_wen_q, ifu_resp_q, lsu_resp_q, misalign_q, bus_err_q;
  logic [31:0] st_wdata, ld_rdata;
  logic [3:0]  st_wmask;
  logic        lsu_mis, tmo;
  lane_align u_align (
    .st_off_i(bus.lsu_addr[1:0]),
    .wdata_i (bus.lsu_wdata),
    .wmask_i (bus.lsu_wmask),
    .wdata_o (st_wdata),
    .wmask_o (st_wmask),
    .ld_off_i(off_q),
    .rdata_i (bus.mem_rdata),
    .rdata_o (ld_rdata)
  );
  assign lsu_mis = misaligned(bus.lsu_size, bus.lsu_addr[1:0]);
`ifdef BUS_ARB_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt_q;
  // held at zero in IDLE so it starts from zero on entering REQ
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= (state_q == IDLE) ? '0 : cnt_q + CW'(1);
  assign tmo = (state_q == REQ || state_q == WAIT) && cnt_q == CW'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IFU;
      off_q       <= '0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      mem_req_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      ifu_resp_q  <= 1'b0;
      lsu_resp_q  <= 1'b0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      ifu_resp_q <= 1'b0;
      lsu_resp_q <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      if (tmo) begin
        state_q   <= RESP;
        mem_req_q <= 1'b0;
        bus_err_q <= 1'b1;
        if (owner_q == OWN_LSU) begin
          lsu_resp_q  <= 1'b1;
          lsu_rdata_q <= DEADBEEF;
        end else begin
          ifu_resp_q  <= 1'b1;
          ifu_rdata_q <= DEADBEEF;
        end
      end else begin
        case (state_q)
          IDLE:
            if (bus.lsu_reqValid) begin
              owner_q <= OWN_LSU;
              if (lsu_mis) begin
                state_q     <= RESP;
                lsu_resp_q  <= 1'b1;
                misalign_q  <= 1'b1;
                lsu_rdata_q <= '0;
              end else begin
                state_q     <= REQ;
                mem_req_q   <= 1'b1;
                off_q       <= bus.lsu_addr[1:0];
                mem_addr_q  <= {bus.lsu_addr[31:2], 2'b00};
                mem_wen_q   <= bus.lsu_wen;
                mem_wdata_q <= bus.lsu_wen ? st_wdata : '0;
                mem_wmask_q <= bus.lsu_wen ? st_wmask : '0;
              end
            end else if (bus.ifu_reqValid) begin
              owner_q     <= OWN_IFU;
              state_q     <= REQ;
              mem_req_q   <= 1'b1;
              off_q       <= '0;
              mem_addr_q  <= bus.ifu_addr & ~32'h3;
              mem_wen_q   <= 1'b0;
              mem_wdata_q <= '0;
              mem_wmask_q <= '0;
            end
          REQ:
            if (bus.mem_ready) begin
              state_q   <= WAIT;
              mem_req_q <= 1'b0;
            end
          WAIT:
            if (bus.mem_rvalid) begin
              state_q <= RESP;
              if (owner_q == OWN_LSU) begin
                lsu_resp_q  <= 1'b1;
                lsu_rdata_q <= ld_rdata;
              end else begin
                ifu_resp_q  <= 1'b1;
                ifu_rdata_q <= bus.mem_rdata;
              end
            end
          RESP: state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign bus.ifu_respValid = ifu_resp_q;
  assign bus.ifu_rdata     = ifu_rdata_q;
  assign bus.lsu_respValid = lsu_resp_q;
  assign bus.lsu_rdata     = lsu_rdata_q;
  assign bus.lsu_misalign  = misalign_q;
  assign bus.mem_req       = mem_req_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wen       = mem_wen_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_wmask     = mem_wmask_q;
  assign bus.bus_err       = bus_err_q;
endmodule

// File: tb/tb_bus_arb.sv
// tb_bus_arb: vector table, directed corner sequences and randomized traffic against a byte-level memory model
module tb_bus_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  bus_arb_if bus ();
`ifdef BUS_ARB_TIMEOUT_EN
  bus_arb #(.TIMEOUT_CYCLES(8)) dut (.clock(clk), .reset(rst), .bus(bus));
`else
  bus_arb dut (.clock(clk), .reset(rst), .bus(bus));
`endif

  int errs = 0;
  int checks = 0;
  int ifu_pulses = 0;
  int lsu_pulses = 0;
  always @(negedge clk) begin
    if (bus.ifu_respValid) ifu_pulses <= ifu_pulses + 1;
    if (bus.lsu_respValid) lsu_pulses <= lsu_pulses + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic        lsu;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] mrd;
    logic        mis;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wmask;
    logic [31:0] e_rdata;
  } vec_t;
  vec_t vecs[11];

  task automatic do_vec(input vec_t v);
    int ip, lp;
    ip = ifu_pulses;
    lp = lsu_pulses;
    if (v.lsu) begin
      bus.lsu_reqValid = 1'b1;
      bus.lsu_addr = v.addr;
      bus.lsu_size = v.size;
      bus.lsu_wen = v.wen;
      bus.lsu_wdata = v.wdata;
      bus.lsu_wmask = v.wmask;
    end else begin
      bus.ifu_reqValid = 1'b1;
      bus.ifu_addr = v.addr;
    end
    tick;
    bus.lsu_reqValid = 1'b0;
    bus.ifu_reqValid = 1'b0;
    bus.lsu_addr = ~v.addr;
    bus.ifu_addr = ~v.addr;
    bus.lsu_wdata = ~v.wdata;
    bus.lsu_wmask = 4'hF;
    bus.lsu_wen = ~v.wen;
    if (v.mis) begin
      chk({v.name, "_resp"}, bus.lsu_respValid, 1);
      chk({v.name, "_misalign"}, bus.lsu_misalign, 1);
      chk({v.name, "_rdata"}, bus.lsu_rdata, 0);
      chk({v.name, "_no_memreq"}, bus.mem_req, 0);
      tick;
      chk({v.name, "_resp_drop"}, bus.lsu_respValid, 0);
    end else begin
      chk({v.name, "_memreq"}, bus.mem_req, 1);
      chk({v.name, "_memaddr"}, bus.mem_addr, v.e_addr);
      chk({v.name, "_memwen"}, bus.mem_wen, v.lsu & v.wen);
      chk({v.name, "_memwdata"}, bus.mem_wdata, v.e_wdata);
      chk({v.name, "_memwmask"}, {28'd0, bus.mem_wmask}, {28'd0, v.e_wmask});
      bus.mem_ready = 1'b1;
      tick;
      bus.mem_ready = 1'b0;
      chk({v.name, "_memreq_drop"}, bus.mem_req, 0);
      chk({v.name, "_early_resp"}, bus.ifu_respValid | bus.lsu_respValid, 0);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata = v.mrd;
      tick;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata = 32'h5A5A_5A5A;
      chk({v.name, "_resp"}, v.lsu ? bus.lsu_respValid : bus.ifu_respValid, 1);
      if (!v.wen) chk({v.name, "_rdata"}, v.lsu ? bus.lsu_rdata : bus.ifu_rdata, v.e_rdata);
      chk({v.name, "_misalign"}, bus.lsu_misalign, 0);
      tick;
      chk({v.name, "_resp_drop"}, bus.ifu_respValid | bus.lsu_respValid, 0);
    end
    tick;
    chk({v.name, "_pulses"}, (lsu_pulses - lp) * 2 + (ifu_pulses - ip), v.lsu ? 2 : 1);
  endtask

  logic [7:0]  ref_b[64];
  logic [31:0] bmem[16];
  logic        acc, pend;
  int          dly;
  logic [31:0] pdata;

  task automatic mem_step;
    int w;
    if (acc) begin
      w = int'(bus.mem_addr[5:2]);
      if (bus.mem_wen)
        for (int b = 0; b < 4; b++)
          if (bus.mem_wmask[b]) bmem[w][8*b +: 8] = bus.mem_wdata[8*b +: 8];
      pdata = bmem[w];
      pend = 1'b1;
      dly = $urandom_range(0, 2);
      acc = 1'b0;
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = $urandom;
    if (pend) begin
      if (dly == 0) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = pdata;
        pend = 1'b0;
      end else dly--;
    end else if (bus.mem_req && $urandom_range(0, 3) == 0) bus.mem_rvalid = 1'b1;
    bus.mem_ready = bus.mem_req && !pend && $urandom_range(0, 2) != 0;
    acc = bus.mem_ready;
  endtask

  initial begin
    int ip, lp;
    bit got;
    bus.ifu_reqValid = 0; bus.ifu_addr = 0; bus.lsu_reqValid = 0; bus.lsu_addr = 0;
    bus.lsu_size = 0; bus.lsu_wen = 0; bus.lsu_wdata = 0; bus.lsu_wmask = 0;
    bus.mem_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
    vecs[0]  = '{"ifu_fetch", 0, 32'h8000_0000, 2'd0, 0, 32'h0, 4'h0, 32'h0010_0093, 0, 32'h8000_0000, 32'h0, 4'h0, 32'h0010_0093};
    vecs[1]  = '{"lb_off3", 1, 32'h1000_0003, 2'd0, 0, 32'h0, 4'h1, 32'hAB11_2233, 0, 32'h1000_0000, 32'h0, 4'h0, 32'h0000_00AB};
    vecs[2]  = '{"sh_off2", 1, 32'h2000_0002, 2'd1, 1, 32'h0000_BEEF, 4'h3, 32'h0, 0, 32'h2000_0000, 32'hBEEF_0000, 4'hC, 32'h0};
    vecs[3]  = '{"lw_mis", 1, 32'h0000_0006, 2'd2, 0, 32'h0, 4'hF, 32'h0, 1, 32'h0, 32'h0, 4'h0, 32'h0};
    vecs[4]  = '{"lh_off2", 1, 32'h0000_0102, 2'd1, 0, 32'h0, 4'h3, 32'h1234_5678, 0, 32'h0000_0100, 32'h0, 4'h0, 32'h0000_1234};
    vecs[5]  = '{"sw", 1, 32'h0000_0040, 2'd2, 1, 32'hCAFE_F00D, 4'hF, 32'h0, 0, 32'h0000_0040, 32'hCAFE_F00D, 4'hF, 32'h0};
    vecs[6]  = '{"sb_off1", 1, 32'h0000_0041, 2'd0, 1, 32'h0000_00A5, 4'h1, 32'h0, 0, 32'h0000_0040, 32'h0000_A500, 4'h2, 32'h0};
    vecs[7]  = '{"lh_mis", 1, 32'h0000_0101, 2'd1, 0, 32'h0, 4'h3, 32'h0, 1, 32'h0, 32'h0, 4'h0, 32'h0};
    vecs[8]  = '{"l3_word", 1, 32'h0000_0008, 2'd3, 0, 32'h0, 4'hF, 32'h1122_3344, 0, 32'h0000_0008, 32'h0, 4'h0, 32'h1122_3344};
    vecs[9]  = '{"l3_mis", 1, 32'h0000_0009, 2'd3, 0, 32'h0, 4'hF, 32'h0, 1, 32'h0, 32'h0, 4'h0, 32'h0};
    vecs[10] = '{"lb_off2", 1, 32'h0000_0002, 2'd0, 0, 32'h0, 4'h1, 32'hAB11_2233, 0, 32'h0000_0000, 32'h0, 4'h0, 32'h0000_AB11};
    tick; tick;
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_resp", {bus.ifu_respValid, bus.lsu_respValid, bus.lsu_misalign, bus.bus_err}, 0);
    chk("rst_rdata", bus.ifu_rdata | bus.lsu_rdata | bus.mem_wdata, 0);
    rst = 1'b0;
    tick;
    foreach (vecs[i]) do_vec(vecs[i]);

    // both requesters at once: lsu first, ifu after
    ip = ifu_pulses; lp = lsu_pulses;
    bus.lsu_reqValid = 1; bus.lsu_addr = 32'h1000_0004; bus.lsu_size = 2; bus.lsu_wen = 0;
    bus.ifu_reqValid = 1; bus.ifu_addr = 32'h0000_0200;
    tick;
    chk("both_lsu_first", bus.mem_addr, 32'h1000_0004);
    bus.lsu_reqValid = 0; bus.mem_ready = 1;
    tick;
    bus.mem_ready = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h1111_1111;
    tick;
    bus.mem_rvalid = 0;
    chk("both_lsu_resp", {bus.lsu_respValid, bus.ifu_respValid}, 2'b10);
    chk("both_lsu_rdata", bus.lsu_rdata, 32'h1111_1111);
    tick;
    chk("both_idle_gap", bus.mem_req, 0);
    tick;
    chk("both_ifu_req", bus.mem_req, 1);
    chk("both_ifu_addr", bus.mem_addr, 32'h0000_0200);
    bus.ifu_reqValid = 0; bus.mem_ready = 1;
    tick;
    bus.mem_ready = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h2222_2222;
    tick;
    bus.mem_rvalid = 0;
    chk("both_ifu_resp", {bus.lsu_respValid, bus.ifu_respValid}, 2'b01);
    chk("both_ifu_rdata", bus.ifu_rdata, 32'h2222_2222);
    tick;
    chk("both_pulse_counts", {ifu_pulses - ip, lsu_pulses - lp}, {32'd1, 32'd1});

    // mem_ready stall with a stray rvalid, then reset mid-REQ
    ip = ifu_pulses; lp = lsu_pulses;
    bus.ifu_reqValid = 1; bus.ifu_addr = 32'h0000_0300;
    tick;
    bus.ifu_reqValid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_memreq", bus.mem_req, 1);
      bus.mem_rvalid = (i == 2);
      tick;
    end
    bus.mem_rvalid = 0;
    chk("stall_bus_err", bus.bus_err, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_memreq", bus.mem_req, 0);
    chk("rst_async_addr", bus.mem_addr, 0);
    tick;
    rst = 1'b0;
    tick; tick; tick;
    chk("rst_abort_no_resp", (ifu_pulses - ip) + (lsu_pulses - lp), 0);
    chk("rst_abort_idle", bus.mem_req, 0);

`ifdef BUS_ARB_TIMEOUT_EN
    bus.ifu_reqValid = 1; bus.ifu_addr = 32'h0000_0400;
    tick;
    bus.ifu_reqValid = 0; bus.mem_ready = 1;
    tick;
    bus.mem_ready = 0;
    got = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.ifu_respValid) begin got = 1; break; end
      tick;
    end
    chk("tmo_resp", got, 1);
    chk("tmo_bus_err", bus.bus_err, 1);
    chk("tmo_rdata", bus.ifu_rdata, 32'hDEAD_BEEF);
    tick;
`endif

    // randomized traffic against a byte-addressed reference memory
    for (int w = 0; w < 16; w++) begin
      bmem[w] = $urandom;
      for (int b = 0; b < 4; b++) ref_b[4*w+b] = bmem[w][8*b +: 8];
    end
    acc = 0; pend = 0; dly = 0; pdata = 0;
    for (int t = 0; t < 300; t++) begin
      bit is_lsu, wen, mis;
      int a, n;
      logic [1:0] size;
      logic [31:0] wdata, exp;
      is_lsu = $urandom_range(0, 2) != 0;
      a = $urandom_range(0, 63);
      size = 2'($urandom_range(0, 3));
      wen = 1'($urandom_range(0, 1));
      wdata = $urandom;
      if (!is_lsu) a = a & ~3;
      mis = is_lsu && ((size == 1 && (a % 2) != 0) || (size >= 2 && (a % 4) != 0));
      n = (size == 0) ? 1 : (size == 1) ? 2 : 4;
      exp = 0;
      if (!is_lsu) exp = {ref_b[a+3], ref_b[a+2], ref_b[a+1], ref_b[a]};
      else if (!mis && !wen) for (int i = 0; i < 4 - (a % 4); i++) exp |= 32'(ref_b[a+i]) << (8*i);
      else if (!mis) for (int i = 0; i < n; i++) ref_b[a+i] = wdata[8*i +: 8];
      if (is_lsu) begin
        bus.lsu_reqValid = 1; bus.lsu_addr = 32'h0000_1000 + 32'(a); bus.lsu_size = size;
        bus.lsu_wen = wen; bus.lsu_wdata = wdata;
        bus.lsu_wmask = (size == 0) ? 4'h1 : (size == 1) ? 4'h3 : 4'hF;
      end else begin
        bus.ifu_reqValid = 1; bus.ifu_addr = 32'h0000_1000 + 32'(a);
      end
      got = 0;
      for (int c = 0; c < 200; c++) begin
        mem_step();
        tick;
        bus.lsu_reqValid = 0; bus.ifu_reqValid = 0;
        if (c == 0) begin bus.lsu_addr = $urandom; bus.lsu_wdata = $urandom; bus.lsu_wen = ~wen; end
        if (is_lsu ? bus.lsu_respValid : bus.ifu_respValid) begin got = 1; break; end
      end
      bus.mem_ready = 0; bus.mem_rvalid = 0;
      acc = 0; pend = 0;
      if (!got) begin
        chk("rand_no_resp", 0, 1);
        rst = 1'b1; tick; rst = 1'b0; tick;
      end else begin
        chk("rand_other_resp", is_lsu ? bus.ifu_respValid : bus.lsu_respValid, 0);
        if (!(is_lsu && wen && !mis)) chk("rand_rdata", is_lsu ? bus.lsu_rdata : bus.ifu_rdata, exp);
        chk("rand_misalign", bus.lsu_misalign, mis);
        tick;
        chk("rand_pulse_one", bus.lsu_respValid | bus.ifu_respValid, 0);
      end
    end
    for (int w = 0; w < 16; w++)
      chk("rand_mem_image", bmem[w], {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]});
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
